axis_dest_route: RTL and testbench

AXIS_DEST_ROUTE -- requirements
Module: axis_dest_route

---
 rtl/axis_dest_route_pkg.sv | 14 +
 rtl/axis_dest_match.sv | 39 +++
 rtl/axis_dest_route.sv | 159 +++++++++++++++
 tb/tb_axis_dest_route.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dest_route_pkg.sv
// axis_dest_route_pkg: shared definitions for the AXI-Stream destination router.
//   state_e     - frame-tracking FSM encoding (HEAD / PASS / DROP)
//   STAT_WIDTH  - width of the optional statistics counters
package axis_dest_route_pkg;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,  // waiting for the first beat of a frame
    ST_PASS = 2'd1,  // forwarding the rest of a routed frame
    ST_DROP = 2'd2   // discarding the rest of an unmatched frame
  } state_e;

  localparam int unsigned STAT_WIDTH = 32;

endpackage

// File: rtl/axis_dest_match.sv
// axis_dest_match: combinational priority matcher over RULE_COUNT masked rules.
//   field_i      - header field taken from the first beat
//   cfg_match_i  - packed per-rule match values (rule 0 in the low bits)
//   cfg_mask_i   - packed per-rule masks
//   cfg_dest_i   - packed per-rule destinations
//   cfg_enable_i - per-rule enable
//   hit_o        - at least one enabled rule matched
//   dest_o       - destination of the lowest-index matching rule (0 when no hit)
module axis_dest_match
  import axis_dest_route_pkg::*;
#(
  parameter int FIELD_WIDTH = 8,
  parameter int DEST_WIDTH  = 3,
  parameter int RULE_COUNT  = 4
) (
  input  logic [FIELD_WIDTH-1:0]            field_i,
  input  logic [RULE_COUNT*FIELD_WIDTH-1:0] cfg_match_i,
  input  logic [RULE_COUNT*FIELD_WIDTH-1:0] cfg_mask_i,
  input  logic [RULE_COUNT*DEST_WIDTH-1:0]  cfg_dest_i,
  input  logic [RULE_COUNT-1:0]             cfg_enable_i,
  output logic                              hit_o,
  output logic [DEST_WIDTH-1:0]             dest_o
);

  always_comb begin
    hit_o  = 1'b0;
    dest_o = '0;
    // Ascending scan; the first hit locks out later rules, giving rule 0 priority.
    for (int unsigned i = 0; i < RULE_COUNT; i++) begin
      if (!hit_o && cfg_enable_i[i] &&
          ((field_i & cfg_mask_i[i*FIELD_WIDTH +: FIELD_WIDTH]) ==
           (cfg_match_i[i*FIELD_WIDTH +: FIELD_WIDTH] & cfg_mask_i[i*FIELD_WIDTH +: FIELD_WIDTH]))) begin
        hit_o  = 1'b1;
        dest_o = cfg_dest_i[i*DEST_WIDTH +: DEST_WIDTH];
      end
    end
  end

endmodule

// File: rtl/axis_dest_route.sv
// axis_dest_route: assigns an AXI-Stream tdest per frame by matching a header
// field of the first beat against RULE_COUNT masked rules; unmatched frames get
// DEFAULT_DEST or are discarded when DROP_UNMATCHED=1. One output register stage.
//   clk, rst            - clock, synchronous active-high reset
//   s_axis_*            - input stream (tready out)
//   m_axis_*            - output stream incl. m_axis_tdest (tready in)
//   cfg_match/mask/dest/enable - rule table, sampled on the first beat only
// Optional: define AXIS_DEST_ROUTE_STATS_EN to add stat_frames / stat_drops.
module axis_dest_route
  import axis_dest_route_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = ((DATA_WIDTH + 7) / 8),
  parameter int DEST_WIDTH     = 3,
  parameter int USER_ENABLE    = 1,
  parameter int USER_WIDTH     = 1,
  parameter int FIELD_OFFSET   = 0,
  parameter int FIELD_WIDTH    = 8,
  parameter int RULE_COUNT     = 4,
  parameter int DEFAULT_DEST   = 0,
  parameter int DROP_UNMATCHED = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]             s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic [USER_WIDTH-1:0]             s_axis_tuser,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest,
  input  logic [RULE_COUNT*FIELD_WIDTH-1:0] cfg_match,
  input  logic [RULE_COUNT*FIELD_WIDTH-1:0] cfg_mask,
  input  logic [RULE_COUNT*DEST_WIDTH-1:0]  cfg_dest,
  input  logic [RULE_COUNT-1:0]             cfg_enable
`ifdef AXIS_DEST_ROUTE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]             stat_frames,
  output logic [STAT_WIDTH-1:0]             stat_drops
`endif
);

  state_e                  state_q;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [KEEP_WIDTH-1:0]   tkeep_q;
  logic                    tvalid_q;
  logic                    tlast_q;
  logic [USER_WIDTH-1:0]   tuser_q;
  logic [DEST_WIDTH-1:0]   tdest_q;

  logic [FIELD_WIDTH-1:0]  field;
  logic                    match_hit;
  logic [DEST_WIDTH-1:0]   match_dest;
  logic [DEST_WIDTH-1:0]   head_dest_d;
  logic [DEST_WIDTH-1:0]   tdest_d;
  logic [KEEP_WIDTH-1:0]   tkeep_d;
  logic [USER_WIDTH-1:0]   tuser_d;
  logic                    drop_now;
  logic                    discard;
  logic                    accept;
  logic                    load;

  assign field = s_axis_tdata[FIELD_OFFSET*8 +: FIELD_WIDTH];

  axis_dest_match #(
    .FIELD_WIDTH (FIELD_WIDTH),
    .DEST_WIDTH  (DEST_WIDTH),
    .RULE_COUNT  (RULE_COUNT)
  ) u_match (
    .field_i      (field),
    .cfg_match_i  (cfg_match),
    .cfg_mask_i   (cfg_mask),
    .cfg_dest_i   (cfg_dest),
    .cfg_enable_i (cfg_enable),
    .hit_o        (match_hit),
    .dest_o       (match_dest)
  );

  assign drop_now    = (DROP_UNMATCHED != 0) && !match_hit;
  assign head_dest_d = match_hit ? match_dest : DEST_WIDTH'(DEFAULT_DEST);
  assign tdest_d     = (state_q == ST_HEAD) ? head_dest_d : dest_q;
  assign tkeep_d     = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign tuser_d     = (USER_ENABLE != 0) ? s_axis_tuser : '0;

  // Discarded beats never touch the output register, so they are always
  // accepted even while a previous beat is stalled downstream. tready depends
  // on tdata (header match) but never on tvalid.
  assign discard       = (state_q == ST_DROP) || ((state_q == ST_HEAD) && drop_now);
  assign s_axis_tready = discard || m_axis_tready || !tvalid_q;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = accept && !discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HEAD;
      dest_q   <= DEST_WIDTH'(DEFAULT_DEST);
      tdest_q  <= DEST_WIDTH'(DEFAULT_DEST);
      tvalid_q <= 1'b0;
    end else begin
      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= s_axis_tdata;
        tkeep_q  <= tkeep_d;
        tlast_q  <= s_axis_tlast;
        tuser_q  <= tuser_d;
        tdest_q  <= tdest_d;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end

      if (accept) begin
        unique case (state_q)
          ST_HEAD: begin
            if (!drop_now) dest_q <= head_dest_d;
            if (!s_axis_tlast) state_q <= drop_now ? ST_DROP : ST_PASS;
          end
          ST_PASS, ST_DROP: begin
            if (s_axis_tlast) state_q <= ST_HEAD;
          end
          default: state_q <= ST_HEAD;
        endcase
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tdest  = tdest_q;

`ifdef AXIS_DEST_ROUTE_STATS_EN
  logic [STAT_WIDTH-1:0] frames_q;
  logic [STAT_WIDTH-1:0] drops_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (tvalid_q && m_axis_tready && tlast_q) frames_q <= frames_q + 1'b1;
      if (accept && (state_q == ST_HEAD) && drop_now) drops_q <= drops_q + 1'b1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_drops  = drops_q;
`endif

endmodule

// File: tb/tb_axis_dest_route.sv
module tb_axis_dest_route;
  import axis_dest_route_pkg::*;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int TW = 3;
  localparam int RC = 4;
  localparam int FW = 8;

  typedef logic [DW+KW+1+1+TW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic [0:0]    s_tuser;
  logic          m_tready;
  logic [RC*FW-1:0] cfg_match, cfg_mask;
  logic [RC*TW-1:0] cfg_dest;
  logic [RC-1:0]    cfg_enable;

  logic rdy_a, rdy_b, v_a, v_b;
  logic [DW-1:0] a_tdata, b_tdata;
  logic [KW-1:0] a_tkeep, b_tkeep;
  logic a_tvalid, b_tvalid, a_tlast, b_tlast;
  logic [0:0] a_tuser, b_tuser;
  logic [TW-1:0] a_tdest, b_tdest;
`ifdef AXIS_DEST_ROUTE_STATS_EN
  logic [31:0] a_frames, a_drops, b_frames, b_drops;
`endif

  // Each instance only sees tvalid when the other is also ready, keeping them in lockstep.
  assign v_a = s_tvalid && rdy_b;
  assign v_b = s_tvalid && rdy_a;

  always #5 clk = ~clk;

  axis_dest_route #(
    .DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_ENABLE(1), .USER_WIDTH(1),
    .FIELD_OFFSET(0), .FIELD_WIDTH(FW), .RULE_COUNT(RC),
    .DEFAULT_DEST(7), .DROP_UNMATCHED(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(v_a),
    .s_axis_tready(rdy_a), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
    .m_axis_tdest(a_tdest),
    .cfg_match(cfg_match), .cfg_mask(cfg_mask), .cfg_dest(cfg_dest), .cfg_enable(cfg_enable)
`ifdef AXIS_DEST_ROUTE_STATS_EN
    , .stat_frames(a_frames), .stat_drops(a_drops)
`endif
  );

  axis_dest_route #(
    .DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_ENABLE(1), .USER_WIDTH(1),
    .FIELD_OFFSET(0), .FIELD_WIDTH(FW), .RULE_COUNT(RC),
    .DEFAULT_DEST(0), .DROP_UNMATCHED(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(v_b),
    .s_axis_tready(rdy_b), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .m_axis_tdest(b_tdest),
    .cfg_match(cfg_match), .cfg_mask(cfg_mask), .cfg_dest(cfg_dest), .cfg_enable(cfg_enable)
`ifdef AXIS_DEST_ROUTE_STATS_EN
    , .stat_frames(b_frames), .stat_drops(b_drops)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  beat_t exp_a[$];
  beat_t exp_b[$];
  logic [7:0] seq = 8'h00;
  bit    stall_a = 1'b0, stall_b = 1'b0;
  beat_t snap_a, snap_b;

  function automatic beat_t pack(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic l, input logic u, input logic [TW-1:0] t);
    return {d, k, l, u, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rule(input int i, input logic [7:0] m, input logic [7:0] k,
                          input logic [2:0] d, input logic en);
    cfg_match[i*FW +: FW] = m;
    cfg_mask[i*FW +: FW]  = k;
    cfg_dest[i*TW +: TW]  = d;
    cfg_enable[i]         = en;
  endtask

  // Samples away from the clock edge, scoreboards output handshakes and
  // checks that stalled outputs hold; returns whether the input beat was taken.
  task automatic cycle(output bit acc);
    beat_t cur_a, cur_b;
    #1;
    acc   = s_tvalid && rdy_a && rdy_b;
    cur_a = pack(a_tdata, a_tkeep, a_tlast, a_tuser, a_tdest);
    cur_b = pack(b_tdata, b_tkeep, b_tlast, b_tuser, b_tdest);
    if (stall_a) chk("A_stall_stable", {a_tvalid, cur_a}, {1'b1, snap_a});
    if (stall_b) chk("B_stall_stable", {b_tvalid, cur_b}, {1'b1, snap_b});
    if (a_tvalid && m_tready) begin
      chk("A_beat_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) chk("A_beat", cur_a, exp_a.pop_front());
    end
    if (b_tvalid && m_tready) begin
      chk("B_beat_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) chk("B_beat", cur_b, exp_b.pop_front());
    end
    stall_a = a_tvalid && !m_tready;
    stall_b = b_tvalid && !m_tready;
    snap_a  = cur_a;
    snap_b  = cur_b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n, input logic [2:0] d_a,
                            input logic [2:0] d_b, input bit drop_b, input int stall_at,
                            input bit lat_chk, input bit cfg_chg);
    bit acc;
    int t;
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d        = {seq, (k == 0) ? hdr : 8'(k)};
      seq      = seq + 8'd1;
      s_tdata  = d;
      s_tkeep  = (k == n - 1) ? 2'b01 : 2'b11;
      s_tlast  = (k == n - 1);
      s_tuser  = 1'(k == 0);
      s_tvalid = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 50) begin
        m_tready = !(k == stall_at && t < 5);
        cycle(acc);
        t++;
      end
      m_tready = 1'b1;
      chk("beat_accepted", 32'(acc), 32'd1);
      if (k == stall_at) chk("stall_cycles", 32'(t), 32'd6);
      exp_a.push_back(pack(d, s_tkeep, s_tlast, s_tuser, d_a));
      if (!drop_b) exp_b.push_back(pack(d, s_tkeep, s_tlast, s_tuser, d_b));
      if (lat_chk && k == 0) begin
        chk("latency_valid", 32'(a_tvalid), 32'd1);
        chk("latency_data", 32'(a_tdata), 32'(d));
      end
      if (cfg_chg && k == 0) cfg_dest[2:0] = 3'd4;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (exp_a.size() != 0 || exp_b.size() != 0); i++) cycle(acc);
    for (int i = 0; i < 2; i++) cycle(acc);
    chk("A_drained", 32'(exp_a.size()), 32'd0);
    chk("B_drained", 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tuser = '0; m_tready = 1'b1;
    cfg_match = '0; cfg_mask = '0; cfg_dest = '0; cfg_enable = '0;
    set_rule(0, 8'h12, 8'hFF, 3'd2, 1'b1);
    set_rule(1, 8'h30, 8'hF0, 3'd3, 1'b1);
    set_rule(2, 8'h55, 8'hFF, 3'd6, 1'b0);
    set_rule(3, 8'h00, 8'h00, 3'd1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_A_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst_B_tvalid", 32'(b_tvalid), 32'd0);
    chk("rst_A_tdest", 32'(a_tdest), 32'd7);
    chk("rst_B_tdest", 32'(b_tdest), 32'd0);
    chk("rst_ready", 32'({rdy_a, rdy_b}), 32'd3);
`ifdef AXIS_DEST_ROUTE_STATS_EN
    chk("rst_stats", {a_frames[7:0], b_frames[7:0], b_drops[7:0]}, 32'd0);
`endif
    @(negedge clk);

    // exact match, 3 beats, 1-cycle latency
    send_frame(8'h12, 3, 3'd2, 3'd2, 1'b0, -1, 1'b1, 1'b0);  drain();
    // masked match on rule 1
    send_frame(8'h3C, 2, 3'd3, 3'd3, 1'b0, -1, 1'b0, 1'b0);  drain();
    // single-beat unmatched (rule 2 disabled): default dest / dropped
    send_frame(8'h55, 1, 3'd7, 3'd0, 1'b1, -1, 1'b0, 1'b0);  drain();
    // 2-beat unmatched frame: default dest / dropped
    send_frame(8'hAA, 2, 3'd7, 3'd0, 1'b1, -1, 1'b0, 1'b0);  drain();
`ifdef AXIS_DEST_ROUTE_STATS_EN
    chk("B_drops_2", b_drops, 32'd2);
`endif
    // downstream stall of 5 cycles mid-frame
    send_frame(8'h12, 4, 3'd2, 3'd2, 1'b0, 2, 1'b0, 1'b0);   drain();
    // overlapping rules: lowest index wins
    set_rule(0, 8'h34, 8'hFF, 3'd5, 1'b1);
    set_rule(1, 8'h34, 8'hFF, 3'd6, 1'b1);
    send_frame(8'h34, 2, 3'd5, 3'd5, 1'b0, -1, 1'b0, 1'b0);  drain();
    // cfg change after first beat only affects the next frame
    set_rule(0, 8'h12, 8'hFF, 3'd2, 1'b1);
    send_frame(8'h12, 3, 3'd2, 3'd2, 1'b0, -1, 1'b0, 1'b1);
    send_frame(8'h12, 1, 3'd4, 3'd4, 1'b0, -1, 1'b0, 1'b0);  drain();
`ifdef AXIS_DEST_ROUTE_STATS_EN
    chk("A_frames_8", a_frames, 32'd8);
    chk("B_frames_6", b_frames, 32'd6);
`endif

    // reset mid-frame: first beat held in the output stage, then reset
    m_tready = 1'b0;
    s_tdata = {seq, 8'h12}; s_tkeep = 2'b11; s_tlast = 1'b0; s_tuser = 1'b1;
    s_tvalid = 1'b1;
    cycle(acc);
    chk("rst_mid_accept", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    stall_a = 1'b0; stall_b = 1'b0;
    #1;
    chk("rst_mid_A_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst_mid_B_tvalid", 32'(b_tvalid), 32'd0);
    chk("rst_mid_A_tdest", 32'(a_tdest), 32'd7);
    m_tready = 1'b1;
    @(negedge clk);
    // next beat is a header: 0x34 hits rule 1 (dest 6), not the abandoned frame's dest
    send_frame(8'h34, 2, 3'd6, 3'd6, 1'b0, -1, 1'b0, 1'b0);  drain();
`ifdef AXIS_DEST_ROUTE_STATS_EN
    chk("post_rst_stats", {a_frames[7:0], b_frames[7:0], b_drops[7:0]}, {8'd0, 8'd1, 8'd1, 8'd0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
